// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : mem_access_unit_pkg                                         |
// | Purpose: Shared encodings for the memory access unit: FSM states,    |
// |          funct3 access-size codes, access sizes and the address      |
// |          origin select values also used by the control FSM.          |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package mem_access_unit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // funct3 access encodings (loads use all five, stores the first three)
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // funct3[1:0] gives the access size for every legal code
   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   // address_origin values
   localparam logic ADDRESS_PC      = 1'b0;
   localparam logic ADDRESS_ALU_REG = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_load_extend.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : mem_access_unit_load_extend                                 |
// | Purpose: Combinational load lane select and sign/zero extension.     |
// | Ports  : rdata   - raw bus word                                      |
// |          addr_lo - byte offset of the access within the word         |
// |          funct3  - access size/sign code (LB/LH/LW/LBU/LHU)          |
// |          data    - extended result                                   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module mem_access_unit_load_extend
   import mem_access_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      addr_lo,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Half-word lanes are selected by addr_lo[1] only; alignment is
   // already guaranteed upstream.
   assign w_byte = rdata[{addr_lo, 3'b000} +: 8];
   assign w_half = rdata[{addr_lo[1], 4'b0000} +: 16];

   always_comb begin
      data = rdata;
      case (funct3)
         F3_B:    data = {{(XLEN-8){w_byte[7]}}, w_byte};
         F3_BU:   data = {{(XLEN-8){1'b0}}, w_byte};
         F3_H:    data = {{(XLEN-16){w_half[15]}}, w_half};
         F3_HU:   data = {{(XLEN-16){1'b0}}, w_half};
         default: data = rdata;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : mem_access_unit                                             |
// | Purpose: Converts level ReadMemory/WriteMemory commands from the     |
// |          multicycle control FSM into a registered req/ack bus        |
// |          transaction, holds the MDR and flags faults/timeouts.       |
// | Ports  : clock, reset_n (async active-low)                           |
// |          read_memory, write_memory, address_origin, pc,              |
// |          alu_result_reg, store_data, funct3 - command side           |
// |          busy, done, fault, mdr            - status/result           |
// |          bus_req/we/addr/be/wdata, bus_rdata, bus_ack - memory bus   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TIMEOUT_W      = 8
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            read_memory,
   input  logic            write_memory,
   input  logic            address_origin,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] alu_result_reg,
   input  logic [XLEN-1:0] store_data,
   input  logic [2:0]      funct3,
   output logic            busy,
   output logic            done,
   output logic            fault,
   output logic [XLEN-1:0] mdr,
   output logic            bus_req,
   output logic            bus_we,
   output logic [XLEN-1:0] bus_addr,
   output logic [3:0]      bus_be,
   output logic [XLEN-1:0] bus_wdata,
   input  logic [XLEN-1:0] bus_rdata,
   input  logic            bus_ack
);

   localparam logic [TIMEOUT_W-1:0] c_limit = TIMEOUT_W'(TIMEOUT_CYCLES);

   state_t                r_state, w_state_next;
   logic [TIMEOUT_W-1:0]  r_cnt, w_cnt_next;
   logic                  r_fault, w_fault_next;
   logic                  r_we;
   logic [XLEN-1:0]       r_addr, r_wdata, r_mdr;
   logic [3:0]            r_be;
   logic [1:0]            r_lo;
   logic [2:0]            r_f3;

   logic [XLEN-1:0]       w_addr, w_wdata, w_load_data;
   logic [2:0]            w_f3;
   logic [1:0]            w_size;
   logic [3:0]            w_be;
   logic                  w_legal_f3, w_misaligned, w_start, w_mdr_load;

   // ---------------- command decode (only meaningful in IDLE) ----------
   assign w_addr = (address_origin == ADDRESS_ALU_REG) ? alu_result_reg : pc;
   // Instruction fetches are always full words regardless of funct3.
   assign w_f3   = (address_origin == ADDRESS_ALU_REG) ? funct3 : F3_W;
   assign w_size = w_f3[1:0];

   always_comb begin
      w_legal_f3 = (w_f3 == F3_B) || (w_f3 == F3_H) || (w_f3 == F3_W);
      if (!write_memory)
         w_legal_f3 = w_legal_f3 || (w_f3 == F3_BU) || (w_f3 == F3_HU);
   end

   assign w_misaligned = ((w_size == SIZE_H) && w_addr[0]) ||
                         ((w_size == SIZE_W) && (w_addr[1:0] != 2'b00));

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = store_data;
      case (w_size)
         SIZE_B: begin
            w_be    = 4'b0001 << w_addr[1:0];
            w_wdata = {(XLEN/8){store_data[7:0]}};
         end
         SIZE_H: begin
            w_be    = 4'b0011 << w_addr[1:0];
            w_wdata = {(XLEN/16){store_data[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = store_data;
         end
      endcase
   end

   mem_access_unit_load_extend #(
      .XLEN    (XLEN)
   ) u_load_extend (
      .rdata   (bus_rdata),
      .addr_lo (r_lo),
      .funct3  (r_f3),
      .data    (w_load_data)
   );

   // ---------------- next-state logic ----------------------------------
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_fault_next = 1'b0;
      w_start      = 1'b0;
      w_mdr_load   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (read_memory && write_memory) begin
               w_fault_next = 1'b1;
            end else if (read_memory || write_memory) begin
               if (!w_legal_f3 || w_misaligned) begin
                  w_fault_next = 1'b1;
               end else begin
                  w_start      = 1'b1;
                  w_cnt_next   = '0;
                  w_state_next = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            // An ack arriving on the final allowed cycle beats the timeout.
            if (bus_ack) begin
               w_mdr_load   = !r_we;
               w_state_next = ST_DONE;
            end else if ((r_cnt + 1'b1) == c_limit) begin
               w_fault_next = 1'b1;
               w_state_next = ST_IDLE;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         ST_DONE: w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // ---------------- registers ----------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_fault <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_be    <= '0;
         r_wdata <= '0;
         r_lo    <= '0;
         r_f3    <= '0;
         r_mdr   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_fault <= w_fault_next;
         if (w_start) begin
            r_we    <= write_memory;
            r_addr  <= {w_addr[XLEN-1:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_lo    <= w_addr[1:0];
            r_f3    <= w_f3;
         end
         if (w_mdr_load)
            r_mdr <= w_load_data;
      end
   end

   assign busy      = (r_state == ST_REQ);
   assign bus_req   = (r_state == ST_REQ);
   assign done      = (r_state == ST_DONE);
   assign fault     = r_fault;
   assign mdr       = r_mdr;
   assign bus_we    = r_we;
   assign bus_addr  = r_addr;
   assign bus_be    = r_be;
   assign bus_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_mem_access_unit                                          |
// | Purpose: Scoreboard bench for mem_access_unit with a responding      |
// |          memory model, directed cases and randomized transactions.   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_mem_access_unit;

   localparam int XLEN = 32;
   localparam int TMO  = 4;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        read_memory = 1'b0, write_memory = 1'b0, address_origin = 1'b0;
   logic [31:0] pc = '0, alu_result_reg = '0, store_data = '0, bus_rdata = '0;
   logic [2:0]  funct3 = '0;
   logic        bus_ack = 1'b0;
   logic        busy, done, fault, bus_req, bus_we;
   logic [31:0] mdr, bus_addr, bus_wdata;
   logic [3:0]  bus_be;

   mem_access_unit #(
      .XLEN           (XLEN),
      .TIMEOUT_CYCLES (TMO),
      .TIMEOUT_W      (8)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .read_memory    (read_memory),
      .write_memory   (write_memory),
      .address_origin (address_origin),
      .pc             (pc),
      .alu_result_reg (alu_result_reg),
      .store_data     (store_data),
      .funct3         (funct3),
      .busy           (busy),
      .done           (done),
      .fault          (fault),
      .mdr            (mdr),
      .bus_req        (bus_req),
      .bus_we         (bus_we),
      .bus_addr       (bus_addr),
      .bus_be         (bus_be),
      .bus_wdata      (bus_wdata),
      .bus_rdata      (bus_rdata),
      .bus_ack        (bus_ack)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int          id;
      bit          is_fault;
      int          req_cycles;
      int          cmd_cyc;
      bit          we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] mdr;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0, checks = 0;
   bit          skip_mon = 1'b0;
   int          mem_wait = 0;
   logic [31:0] mem_rdata = '0;
   logic [31:0] model_mdr = '0;
   int          txn_id = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic finish_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   endtask

   // Reference model: outcome of one command from the access rules.
   function automatic exp_t model(input bit rd, input bit wr, input bit org,
                                  input logic [31:0] pcv, input logic [31:0] alu,
                                  input logic [31:0] sd, input logic [2:0] f3,
                                  input int wt, input logic [31:0] rdata);
      exp_t        e;
      logic [31:0] addr, val;
      logic [2:0]  f;
      int          sz, lo;
      bit          legal;
      e = '{default: 0};
      addr = org ? alu : pcv;
      f    = org ? f3 : 3'b010;
      lo   = int'(addr[1:0]);
      if (wr) legal = (f == 3'd0) || (f == 3'd1) || (f == 3'd2);
      else    legal = (f == 3'd0) || (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd5);
      sz = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
      if ((rd && wr) || !legal || ((lo % sz) != 0)) begin
         e.is_fault = 1; e.req_cycles = 0; e.mdr = model_mdr;
         return e;
      end
      e.we    = wr;
      e.addr  = addr & ~32'h3;
      e.be    = 4'(((1 << sz) - 1) << lo);
      e.wdata = (sz == 1) ? sd[7:0] * 32'h01010101 :
                (sz == 2) ? sd[15:0] * 32'h00010001 : sd;
      if (wt >= TMO) begin
         e.is_fault = 1; e.req_cycles = TMO;
      end else begin
         e.is_fault = 0; e.req_cycles = wt + 1;
         if (!wr) begin
            val = rdata >> (8 * lo);
            if (sz == 1) begin
               val = val & 32'hFF;
               if (f == 3'd0 && val[7]) val = val | 32'hFFFFFF00;
            end else if (sz == 2) begin
               val = val & 32'hFFFF;
               if (f == 3'd1 && val[15]) val = val | 32'hFFFF0000;
            end
            model_mdr = val;
         end
      end
      e.mdr = model_mdr;
      return e;
   endfunction

   // Memory: acks after mem_wait idle request cycles.
   initial begin
      int rc = 0;
      forever begin
         @(posedge clock); #1;
         if (bus_req === 1'b1) begin
            bus_ack   = (rc == mem_wait);
            bus_rdata = bus_ack ? mem_rdata : $urandom;
            rc++;
         end else begin
            rc = 0;
            bus_ack = 1'b0;
            bus_rdata = $urandom;
         end
      end
   end

   // Monitor: tracks the request phase and checks each completion/fault.
   initial begin
      bit          prev_req = 0, unstable = 0, busy_bad = 0, cwe = 0;
      int          rq = 0;
      logic [31:0] ca = '0, cw = '0;
      logic [3:0]  cb = '0;
      exp_t        e;
      forever begin
         @(negedge clock);
         if (skip_mon || !reset_n) begin
            prev_req = 0; rq = 0; unstable = 0; busy_bad = 0;
            continue;
         end
         if (busy !== bus_req) busy_bad = 1;
         if (bus_req) begin
            if (!prev_req) begin
               ca = bus_addr; cb = bus_be; cw = bus_wdata; cwe = bus_we; rq = 1;
            end else begin
               rq++;
               if (bus_addr !== ca || bus_be !== cb || bus_wdata !== cw || bus_we !== cwe)
                  unstable = 1;
            end
         end
         prev_req = bus_req;
         if (done || fault) begin
            if (sb.size() == 0) begin
               chk("unexpected_event", 1, 0);
            end else begin
               e = sb.pop_front();
               chk($sformatf("txn%0d_fault", e.id), fault, e.is_fault);
               chk($sformatf("txn%0d_done", e.id), done, !e.is_fault);
               chk($sformatf("txn%0d_req_cycles", e.id), rq, e.req_cycles);
               chk($sformatf("txn%0d_latency", e.id), cyc - e.cmd_cyc, e.req_cycles + 1);
               chk($sformatf("txn%0d_mdr", e.id), mdr, e.mdr);
               chk($sformatf("txn%0d_busy", e.id), busy_bad, 0);
               if (e.req_cycles > 0) begin
                  chk($sformatf("txn%0d_addr", e.id), ca, e.addr);
                  chk($sformatf("txn%0d_be", e.id), cb, e.be);
                  chk($sformatf("txn%0d_we", e.id), cwe, e.we);
                  chk($sformatf("txn%0d_stable", e.id), unstable, 0);
                  if (e.we) chk($sformatf("txn%0d_wdata", e.id), cw, e.wdata);
               end
            end
            rq = 0; unstable = 0; busy_bad = 0;
         end
      end
   end

   task automatic wait_drain();
      for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clock);
      #1;
      if (sb.size() != 0) begin
         chk("drain_timeout", sb.size(), 0);
         finish_run();
      end
   endtask

   // Called just after a rising edge; command is held for one cycle.
   task automatic issue(input bit rd, input bit wr, input bit org,
                        input logic [31:0] pcv, input logic [31:0] alu,
                        input logic [31:0] sd, input logic [2:0] f3,
                        input int wt, input logic [31:0] rdata);
      exp_t e;
      mem_wait = wt; mem_rdata = rdata;
      read_memory = rd; write_memory = wr; address_origin = org;
      pc = pcv; alu_result_reg = alu; store_data = sd; funct3 = f3;
      e = model(rd, wr, org, pcv, alu, sd, f3, wt, rdata);
      e.id = txn_id++;
      e.cmd_cyc = cyc;
      sb.push_back(e);
      @(posedge clock); #1;
      read_memory = 0; write_memory = 0;
      // Scramble command-side inputs to expose any use of live values.
      pc = $urandom; alu_result_reg = $urandom; store_data = $urandom;
      funct3 = 3'($urandom); address_origin = 1'($urandom);
      wait_drain();
   endtask

   initial begin
      #200000;
      chk("global_timeout", 1, 0);
      finish_run();
   end

   initial begin
      logic [2:0] legal_f3 [5];
      legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2;
      legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;

      repeat (3) @(posedge clock);
      #1;
      chk("rst_busy", busy, 0);      chk("rst_done", done, 0);
      chk("rst_fault", fault, 0);    chk("rst_req", bus_req, 0);
      chk("rst_we", bus_we, 0);      chk("rst_addr", bus_addr, 0);
      chk("rst_be", bus_be, 0);      chk("rst_wdata", bus_wdata, 0);
      chk("rst_mdr", mdr, 0);
      reset_n = 1'b1;
      @(posedge clock); #1;

      // Directed cases
      issue(1, 0, 0, 32'h100, 32'h0, 32'h0, 3'b111, 0, 32'h00500093); // fetch
      issue(1, 0, 1, 32'h0, 32'h203, 32'h0, 3'b000, 3, 32'h80FF1234); // LB
      issue(1, 0, 1, 32'h0, 32'h203, 32'h0, 3'b100, 3, 32'h80FF1234); // LBU
      issue(0, 1, 1, 32'h0, 32'h402, 32'h0000BEEF, 3'b001, 1, 32'h0); // SH
      issue(1, 0, 1, 32'h0, 32'h206, 32'h0, 3'b010, 0, 32'h0);        // LW misaligned
      issue(1, 1, 1, 32'h0, 32'h200, 32'h0, 3'b010, 0, 32'h0);        // both commands
      issue(1, 0, 1, 32'h0, 32'h200, 32'h0, 3'b011, 0, 32'h0);        // illegal funct3
      issue(1, 0, 1, 32'h0, 32'h204, 32'h0, 3'b010, 100, 32'h0);      // timeout
      issue(1, 0, 1, 32'h0, 32'h204, 32'h0, 3'b010, TMO - 1, 32'h13572468); // ack on last cycle
      issue(0, 1, 1, 32'h0, 32'h100, 32'h0, 3'b110, 0, 32'h0);        // illegal store code

      // Randomized traffic
      for (int i = 0; i < 80; i++) begin
         int          r;
         bit          rd, wr, org;
         logic [2:0]  f;
         r   = int'($urandom_range(0, 9));
         rd  = (r == 0) || (r < 6);
         wr  = (r == 0) || (r >= 6);
         org = ($urandom_range(0, 3) != 0);
         f   = ($urandom_range(0, 3) == 0) ? 3'($urandom) : legal_f3[$urandom_range(0, 4)];
         issue(rd, wr, org, $urandom, $urandom, $urandom, f,
               int'($urandom_range(0, 5)), $urandom);
      end

      // Asynchronous reset during the second request cycle
      issue(1, 0, 1, 32'h0, 32'h300, 32'h0, 3'b010, 0, 32'hCAFEF00D);
      skip_mon = 1'b1;
      mem_wait = 20;
      read_memory = 1; address_origin = 1; alu_result_reg = 32'h300; funct3 = 3'b010;
      @(posedge clock); #1;
      read_memory = 0;
      @(posedge clock); #3;
      reset_n = 1'b0;
      #1;
      chk("async_rst_req", bus_req, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_mdr", mdr, 0);
      model_mdr = '0;
      @(posedge clock); #2;
      reset_n = 1'b1;
      skip_mon = 1'b0;
      @(posedge clock); #1;
      issue(1, 0, 1, 32'h0, 32'h308, 32'h0, 3'b010, 2, 32'h0BADBEEF);

      repeat (2) @(posedge clock);
      finish_run();
   end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Downstream of the multicycle control FSM. Turns its one-cycle-level ReadMemory/WriteMemory commands into a req/ack transaction on a variable-latency memory bus.
- Holds the memory data register (MDR) that feeds the register write-back mux.
- Stalls the control FSM via busy/done and reports alignment faults, illegal commands and bus timeouts.

Parameters:
- XLEN, 32, datapath and address width.
- TIMEOUT_CYCLES, 255, maximum wait for bus_ack before aborting.
- TIMEOUT_W, 8, width of the wait counter; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- read_memory  in  1  read command from the control FSM.
- write_memory  in  1  write command from the control FSM.
- address_origin  in  1  0 = PC (instruction fetch), 1 = registered ALU result.
- pc  in  XLEN  current PC.
- alu_result_reg  in  XLEN  registered ALU output (load/store address).
- store_data  in  XLEN  rs2 value for stores.
- funct3  in  3  access size/sign field from the instruction register.
- busy  out  1  transaction in progress; control holds its state while busy is high.
- done  out  1  one-cycle pulse when the transaction completes.
- fault  out  1  one-cycle pulse on misalignment, illegal command or timeout.
- mdr  out  XLEN  extended load data or fetched instruction.
- bus_req  out  1  request, registered.
- bus_we  out  1  write enable, registered.
- bus_addr  out  XLEN  word-aligned address, registered.
- bus_be  out  4  byte enables, registered.
- bus_wdata  out  XLEN  lane-replicated store data, registered.
- bus_rdata  in  XLEN  read data; valid when bus_ack is high.
- bus_ack  in  1  completion from memory; may rise in any cycle while bus_req is high.

Behaviour:
- Reset: state IDLE. busy, done, fault, bus_req, bus_we = 0. bus_addr, bus_be, bus_wdata, mdr = 0. Wait counter = 0.
- Reset is asynchronous: if it asserts mid-transaction, bus_req drops immediately, the transaction is abandoned and mdr clears.
- States:
  - IDLE: accept commands. busy = 0.
  - REQ: bus_req = 1 and all bus outputs held stable. busy = 1.
  - DONE: done = 1 for one cycle, busy = 0, then return to IDLE.
- Command acceptance happens only in IDLE; commands are ignored in REQ and DONE.
- IDLE, read_memory and write_memory both 1: fault pulse, no bus activity, stay IDLE.
- IDLE, exactly one command high:
  - Effective address = address_origin ? alu_result_reg : pc.
  - Fetch (address_origin = 0) forces word size; funct3 is ignored.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other funct3 raises fault.
  - Alignment rule: half-word requires addr[0] = 0; word requires addr[1:0] = 0. A violation raises fault.
  - On fault: one-cycle fault pulse, no bus_req, stay IDLE, mdr unchanged.
  - Otherwise: register bus_addr = {addr[XLEN-1:2], 00}, bus_we = write, bus_be, bus_wdata; go to REQ. bus_req is high in the next cycle.
- Byte enables: byte = 0001 << addr[1:0]; half = 0011 << addr[1:0]; word = 1111.
- Write data: byte replicated to all 4 lanes, half replicated to 2 lanes, word passed through.
- REQ, bus_ack = 1:
  - On a read, capture the lane selected by addr[1:0] into mdr, sign- or zero-extended per funct3 (fetch/LW take the full word).
  - Deassert bus_req next cycle, go to DONE.
- REQ, no ack: wait counter increments each cycle. When it reaches TIMEOUT_CYCLES: fault pulse, bus_req deasserted, IDLE, mdr unchanged.
  - An ack in the same cycle the counter reaches the limit wins over the timeout.
- Latency: command seen in cycle 0, bus_req from cycle 1, ack in cycle k ≥ 1, done and mdr valid in cycle k+1. A zero-wait memory gives done in cycle 2.
- mdr holds its value until the next successful read.
- Writes never modify mdr.
- The wait counter clears on entering REQ.

Decomposition:
- Shared package:
  - funct3 size encodings.
  - State encodings: IDLE, REQ, DONE.
  - ADDRESS_PC / ADDRESS_ALU_REG origin constants, shared with the control FSM.
- One sub-module: load_extend. Combinational; takes rdata, addr[1:0] and funct3 and produces the extended XLEN value. It is reusable by a future pipelined core.

Test Plan:
- Fetch: pc = 0x100, funct3 = 111, memory acks in the same cycle as req with rdata 0x00500093 -> bus_addr = 0x100, be = 1111, no fault; done in cycle 2; mdr = 0x00500093.
- LB: alu_result_reg = 0x203, rdata = 0x80FF1234, ack after 3 wait cycles -> be = 1000; done in cycle 5; mdr = 0xFFFFFF80. Repeat with LBU -> mdr = 0x00000080.
- SH: alu_result_reg = 0x402, store_data = 0x0000BEEF -> bus_we = 1, be = 1100, wdata = 0xBEEFBEEF; mdr unchanged after done.
- LW at 0x206, read and write both high, and funct3 = 011 -> each case gives a single fault pulse, bus_req never asserts, busy stays 0.
- TIMEOUT_CYCLES = 4, no ack -> bus_req high for exactly 4 cycles, then fault pulse and IDLE. A second run with ack in the 4th cycle -> done, no fault.
- reset_n low in the 2nd REQ cycle -> bus_req, busy and mdr at 0 in the same cycle. After release, a new LW completes normally.
